// File: rtl/exec_writeback.sv
// Execute stage feeding the register-file write port: single-cycle ALU plus an
// optional iterative 16-step shift-add multiplier enabled by the EXEC_MUL_EN macro.
module exec_writeback #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        codop,
  input  logic [WIDTH-1:0]  op_a,
  input  logic [WIDTH-1:0]  op_b,
  input  logic [ADDR_W-1:0] dest,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [WIDTH-1:0]  wb_data,
  output logic              busy
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MOV = 4'd9;
  localparam logic [3:0] OP_SLT = 4'd10;

  localparam int SH_STAGES = 4;

  // Logarithmic shifters: stage gi shifts by 2**gi when op_b[gi] is set.
  logic [WIDTH-1:0] shl_stage [0:SH_STAGES];
  logic [WIDTH-1:0] shr_stage [0:SH_STAGES];

  assign shl_stage[0] = op_a;
  assign shr_stage[0] = op_a;

  genvar gi;
  generate
    for (gi = 0; gi < SH_STAGES; gi++) begin : g_shift
      localparam int DIST = 1 << gi;
      assign shl_stage[gi+1] = op_b[gi] ? (shl_stage[gi] << DIST) : shl_stage[gi];
      assign shr_stage[gi+1] = op_b[gi] ? (shr_stage[gi] >> DIST) : shr_stage[gi];
    end
  endgenerate

  logic slt_bit;
  assign slt_bit = $signed(op_a) < $signed(op_b);

  logic [WIDTH-1:0] alu_result;
  logic             alu_writes;

  always_comb begin
    alu_result = '0;
    alu_writes = 1'b1;
    case (codop)
      OP_ADD:  alu_result = op_a + op_b;
      OP_SUB:  alu_result = op_a - op_b;
      OP_AND:  alu_result = op_a & op_b;
      OP_OR:   alu_result = op_a | op_b;
      OP_XOR:  alu_result = op_a ^ op_b;
      OP_NOT:  alu_result = ~op_a;
      OP_SHL:  alu_result = shl_stage[SH_STAGES];
      OP_SHR:  alu_result = shr_stage[SH_STAGES];
      OP_MOV:  alu_result = op_a;
      OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, slt_bit};
      // MUL is not a single-cycle op; NOPs never write.
      default: alu_writes = 1'b0;
    endcase
  end

  logic              wb_en_reg,   wb_en_next;
  logic [ADDR_W-1:0] wb_addr_reg, wb_addr_next;
  logic [WIDTH-1:0]  wb_data_reg, wb_data_next;

`ifdef EXEC_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t            state_reg,  state_next;
  logic [WIDTH-1:0]  mcand_reg,  mcand_next;
  logic [WIDTH-1:0]  mplier_reg, mplier_next;
  logic [WIDTH-1:0]  acc_reg,    acc_next;
  logic [3:0]        count_reg,  count_next;
  logic [ADDR_W-1:0] mdest_reg,  mdest_next;
  logic [WIDTH-1:0]  step_sum;

  assign step_sum = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      count_reg  <= '0;
      mdest_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      acc_reg    <= acc_next;
      count_reg  <= count_next;
      mdest_reg  <= mdest_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    mcand_next   = mcand_reg;
    mplier_next  = mplier_reg;
    acc_next     = acc_reg;
    count_next   = count_reg;
    mdest_next   = mdest_reg;
    wb_en_next   = 1'b0;
    wb_addr_next = wb_addr_reg;
    wb_data_next = wb_data_reg;
    in_ready     = 1'b0;
    busy         = 1'b0;
    case (state_reg)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (codop == OP_MUL) begin
            state_next  = S_MUL;
            mcand_next  = op_a;
            mplier_next = op_b;
            acc_next    = '0;
            count_next  = '0;
            mdest_next  = dest;
          end else if (alu_writes) begin
            wb_en_next   = 1'b1;
            wb_addr_next = dest;
            wb_data_next = alu_result;
          end
        end
      end
      S_MUL: begin
        busy        = 1'b1;
        acc_next    = step_sum;
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_reg >> 1;
        count_next  = count_reg + 4'd1;
        // The sixteenth step writes its own sum straight out.
        if (count_reg == 4'd15) begin
          state_next   = S_IDLE;
          wb_en_next   = 1'b1;
          wb_addr_next = mdest_reg;
          wb_data_next = step_sum;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end
`else
  always_comb begin
    in_ready     = 1'b1;
    busy         = 1'b0;
    wb_en_next   = 1'b0;
    wb_addr_next = wb_addr_reg;
    wb_data_next = wb_data_reg;
    if (in_valid && alu_writes) begin
      wb_en_next   = 1'b1;
      wb_addr_next = dest;
      wb_data_next = alu_result;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_en_reg   <= 1'b0;
      wb_addr_reg <= '0;
      wb_data_reg <= '0;
    end else begin
      wb_en_reg   <= wb_en_next;
      wb_addr_reg <= wb_addr_next;
      wb_data_reg <= wb_data_next;
    end
  end

  assign wb_en   = wb_en_reg;
  assign wb_addr = wb_addr_reg;
  assign wb_data = wb_data_reg;

endmodule
